// File: rtl/bsearch_sequencer.sv
// bsearch_sequencer: binary search for a target over a sorted synchronous RAM
// with one-cycle read latency; result held until start is released.
// Ports: clk, reset (async, active high), start, target, q (RAM data) in;
//        rd_addr, busy, done, found, result_addr out;
//        probe_cnt out only when BSEARCH_STATS_EN is defined.
module bsearch_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] target,
   input  logic [DATA_W-1:0] q,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] result_addr
`ifdef BSEARCH_STATS_EN
   ,
   output logic [ADDR_W:0]   probe_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_WAIT,
      S_CMP,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t state_q, state_d;
   logic [ADDR_W-1:0] low_q, low_d;
   logic [ADDR_W-1:0] high_q, high_d;
   logic [DATA_W-1:0] tgt_q, tgt_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic              found_q, found_d;
   logic [ADDR_W-1:0] res_q, res_d;
`ifdef BSEARCH_STATS_EN
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
   logic [ADDR_W:0]   cnt_q, cnt_d;
`endif

   // One extra bit on the sum so low+high cannot overflow.
   logic [ADDR_W:0]   sum;
   logic [ADDR_W-1:0] mid;

   assign sum = {1'b0, low_q} + {1'b0, high_q};
   assign mid = ADDR_W'(sum >> 1);

   always_comb begin
      state_d = state_q;
      low_d   = low_q;
      high_d  = high_q;
      tgt_d   = tgt_q;
      rd_d    = rd_q;
      found_d = found_q;
      res_d   = res_q;
`ifdef BSEARCH_STATS_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               low_d   = '0;
               high_d  = '1;
               tgt_d   = target;
               found_d = 1'b0;
               res_d   = '0;
`ifdef BSEARCH_STATS_EN
               cnt_d   = '0;
`endif
               state_d = S_SET;
            end
         end
         S_SET: begin
            rd_d    = mid;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_CMP;
         end
         S_CMP: begin
`ifdef BSEARCH_STATS_EN
            cnt_d = cnt_q + CNT_ONE;
`endif
            // End checks on the bounds keep low/high from wrapping.
            unique case (1'b1)
               (q == tgt_q): begin
                  found_d = 1'b1;
                  res_d   = rd_q;
                  state_d = S_DONE;
               end
               (q < tgt_q): begin
                  if (rd_q == high_q) begin
                     state_d = S_DONE;
                  end else begin
                     low_d   = rd_q + ONE;
                     state_d = S_SET;
                  end
               end
               default: begin
                  if (rd_q == low_q) begin
                     state_d = S_DONE;
                  end else begin
                     high_d  = rd_q - ONE;
                     state_d = S_SET;
                  end
               end
            endcase
         end
         S_DONE: begin
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         low_q   <= '0;
         high_q  <= '1;
         tgt_q   <= '0;
         rd_q    <= '0;
         found_q <= 1'b0;
         res_q   <= '0;
`ifdef BSEARCH_STATS_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         low_q   <= low_d;
         high_q  <= high_d;
         tgt_q   <= tgt_d;
         rd_q    <= rd_d;
         found_q <= found_d;
         res_q   <= res_d;
`ifdef BSEARCH_STATS_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign rd_addr     = rd_q;
   assign busy        = (state_q == S_SET) ||
                        (state_q == S_WAIT) ||
                        (state_q == S_CMP);
   assign done        = (state_q == S_DONE);
   assign found       = found_q;
   assign result_addr = res_q;
`ifdef BSEARCH_STATS_EN
   assign probe_cnt   = cnt_q;
`endif

endmodule
